// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 access
// codes, FSM state type, byte-mask width and small decode helpers.
package lsu_pkg;

  // Access-size codes carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size field is funct3[1:0]; the sign/zero choice lives in funct3[2]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // One write-enable bit per byte lane of the 32-bit data bus
  localparam int BMASK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Loads accept all five codes; stores only have signed-style B/H/W
  function automatic logic f3_legal(input logic [2:0] funct3,
                                    input logic       is_load);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = is_load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need an even address, words a multiple of four
  function automatic logic f3_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Lanes written by a store of the given size at the given byte offset
  function automatic logic [BMASK_W-1:0] st_bmask(input logic [1:0] size,
                                                  input logic [1:0] addr_lo);
    logic [BMASK_W-1:0] mask;
    mask = '0;
    case (size)
      SZ_BYTE: mask = 4'b0001 << addr_lo;
      SZ_HALF: mask = 4'b0011 << {addr_lo[1], 1'b0};
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Replicate narrow store data across every lane so the mask alone selects
  function automatic logic [31:0] st_wdata(input logic [1:0]  size,
                                           input logic [31:0] data);
    logic [31:0] wd;
    wd = data;
    case (size)
      SZ_BYTE: wd = {4{data[7:0]}};
      SZ_HALF: wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/ld_align.sv
// Load formatter: picks the addressed byte/halfword lane out of a full bus
// word and sign- or zero-extends it according to funct3.
module ld_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection from the low address bits
  always_comb begin
    byte_sel = rdata[7:0];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
  end

  // Extension to 32 bits by access type
  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_W:    data = rdata;
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit. Turns a MEM-stage load or store into a
// single request/ack transaction on the data-memory bus, stalling the
// pipeline until it completes, and aborts with a bus error if the memory
// does not answer within TIMEOUT_CYC request cycles.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               is_load_i,
  input  logic               is_store_i,
  input  logic [2:0]         funct3_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        st_data_i,
  output logic               stall_o,
  output logic [31:0]        ld_data_o,
  output logic               ld_valid_o,
  output logic               misalign_o,
  output logic               bus_err_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [31:0]        dmem_addr_o,
  output logic [31:0]        dmem_wdata_o,
  output logic [BMASK_W-1:0] dmem_bmask_o,
  input  logic               dmem_ack_i,
  input  logic [31:0]        dmem_rdata_i
);

  // Wide enough to hold TIMEOUT_CYC itself; expiry is judged on the last
  // REQ cycle, when the count of ack-less cycles so far is TIMEOUT_CYC-1.
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e       state, state_n;
  logic [CNT_W-1:0] tmo_cnt;

  logic             mem_op;
  logic             op_legal;
  logic             op_misaligned;
  logic             start;
  logic             stall_raw;
  logic             misalign_raw;
  logic             acked;
  logic             timed_out;

  logic             is_load_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic [31:0]      ld_fmt;

  // Decode of the instruction currently presented by the MEM stage
  always_comb begin
    mem_op        = valid_i & (is_load_i | is_store_i);
    op_legal      = f3_legal(funct3_i, is_load_i);
    op_misaligned = f3_misaligned(funct3_i[1:0], addr_i[1:0]);
    start         = mem_op & op_legal & ~op_misaligned;
    acked         = (state == ST_REQ) & dmem_ack_i;
    timed_out     = (state == ST_REQ) & ~dmem_ack_i & (tmo_cnt == CNT_LAST);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic plus the combinational stall and misalign strobes
  always_comb begin
    state_n      = state;
    stall_raw    = 1'b0;
    misalign_raw = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_raw    = start;
        misalign_raw = mem_op & op_legal & op_misaligned;
        if (start) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        stall_raw = 1'b1;
        if (dmem_ack_i || timed_out) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // While reset is held the pipeline must not be frozen or see an exception
  assign stall_o    = rst_i & stall_raw;
  assign misalign_o = rst_i & misalign_raw;
  assign dmem_req_o = (state == ST_REQ);

  // Capture the bus transaction on the start cycle and hold it through REQ
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_bmask_o <= '0;
      dmem_we_o    <= 1'b0;
      is_load_q    <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
    end else if ((state == ST_IDLE) && start) begin
      dmem_addr_o  <= {addr_i[31:2], 2'b00};
      dmem_we_o    <= ~is_load_i;
      dmem_bmask_o <= is_load_i ? '0 : st_bmask(funct3_i[1:0], addr_i[1:0]);
      dmem_wdata_o <= is_load_i ? '0 : st_wdata(funct3_i[1:0], st_data_i);
      is_load_q    <= is_load_i;
      funct3_q     <= funct3_i;
      addr_lo_q    <= addr_i[1:0];
    end
  end

  // Ack-less REQ cycle counter, restarted for every new transaction
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tmo_cnt <= '0;
    end else if ((state == ST_IDLE) && start) begin
      tmo_cnt <= '0;
    end else if ((state == ST_REQ) && !dmem_ack_i) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  ld_align u_ld_align (
    .rdata  (dmem_rdata_i),
    .funct3 (funct3_q),
    .addr   (addr_lo_q),
    .data   (ld_fmt)
  );

  // Completion results, all visible during the single DONE cycle
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ld_data_o  <= '0;
      ld_valid_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      ld_valid_o <= acked & is_load_q;
      bus_err_o  <= timed_out;
      if (acked && is_load_q) begin
        ld_data_o <= ld_fmt;
      end else if (timed_out) begin
        ld_data_o <= '0;
      end
    end
  end

endmodule
